// File: rtl/audio_stream_fetch.sv
// Audio playback fetch engine: keeps the I2S FIFO topped up from SDRAM with fixed-length
// read bursts, walking a track region once or in a loop.
module audio_stream_fetch #(
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned LVL_W     = 11,
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned LOW_WATER = 1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              init_done_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_en_i,
    input  logic [ADDR_W-1:0] track_base_i,
    input  logic [23:0]       track_len_i,
    output logic              sdram_rd_o,
    output logic [ADDR_W-1:0] sdram_addr_o,
    input  logic              sdram_ac_i,
    input  logic [15:0]       sdram_data_i,
    input  logic              sdram_wait_i,
    output logic              fifo_wrreq_o,
    output logic [15:0]       fifo_data_o,
    input  logic [LVL_W-1:0]  fifo_wrusedw_i,
    input  logic              fifo_wrfull_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o,
    output logic [15:0]       stall_cnt_o
);

    localparam int unsigned      BCNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [LVL_W-1:0] LowWater  = LVL_W'(LOW_WATER);
    localparam logic [BCNT_W-1:0] BurstLen = BCNT_W'(BURST_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StLevel,
        StBurst,
        StDrainStop
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [23:0]         remain_q, remain_d;
    logic [23:0]         len_q, len_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                done_q, done_d;
    logic                underrun_q, underrun_d;
    logic                burst_seen_q, burst_seen_d;
    logic [15:0]         stall_q, stall_d;

    // A request, once raised, stays up until acknowledged, even across a stop.
    assign sdram_rd_o   = (state_q == StBurst) || (state_q == StDrainStop);
    assign sdram_addr_o = cur_q;
    assign fifo_wrreq_o = sdram_rd_o && sdram_ac_i && !reset_i;
    assign fifo_data_o  = sdram_data_i;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;
    assign underrun_o   = underrun_q;
    assign stall_cnt_o  = stall_q;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        base_d       = base_q;
        remain_d     = remain_q;
        len_d        = len_q;
        bcnt_d       = bcnt_q;
        done_d       = done_q;
        underrun_d   = underrun_q;
        burst_seen_d = burst_seen_q;
        stall_d      = stall_q;

        if (sdram_rd_o && sdram_wait_i && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end

        if (busy_o && burst_seen_q && (fifo_wrusedw_i == '0) && !fifo_wrfull_i) begin
            underrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i && init_done_i && !stop_i) begin
                    base_d       = track_base_i;
                    len_d        = track_len_i;
                    cur_d        = track_base_i;
                    remain_d     = track_len_i;
                    done_d       = 1'b0;
                    underrun_d   = 1'b0;
                    burst_seen_d = 1'b0;
                    stall_d      = 16'd0;
                    if (track_len_i == 24'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StLevel;
                    end
                end
            end

            StLevel: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else if ((fifo_wrusedw_i < LowWater) && !fifo_wrfull_i) begin
                    state_d = StBurst;
                    bcnt_d  = BurstLen;
                end
            end

            StBurst: begin
                if (sdram_ac_i) begin
                    cur_d    = cur_q + ADDR_W'(1);
                    remain_d = remain_q - 24'd1;
                    bcnt_d   = bcnt_q - BCNT_W'(1);
                    if (stop_i) begin
                        state_d = StIdle;
                    end else if (remain_q == 24'd1) begin
                        if (loop_en_i) begin
                            cur_d    = base_q;
                            remain_d = len_q;
                            // A wrap landing on the last word of a burst still ends the burst.
                            if (bcnt_q == BCNT_W'(1)) begin
                                state_d      = StLevel;
                                burst_seen_d = 1'b1;
                            end
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else if (bcnt_q == BCNT_W'(1)) begin
                        state_d      = StLevel;
                        burst_seen_d = 1'b1;
                    end
                end else if (stop_i) begin
                    state_d = StDrainStop;
                end
            end

            StDrainStop: begin
                if (sdram_ac_i) begin
                    cur_d   = cur_q + ADDR_W'(1);
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            base_q       <= '0;
            remain_q     <= '0;
            len_q        <= '0;
            bcnt_q       <= '0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            burst_seen_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            base_q       <= base_d;
            remain_q     <= remain_d;
            len_q        <= len_d;
            bcnt_q       <= bcnt_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
            burst_seen_q <= burst_seen_d;
            stall_q      <= stall_d;
        end
    end

endmodule

// File: tb/tb_audio_stream_fetch.sv
// Directed bench for audio_stream_fetch with a delayed-ack SDRAM responder and write logger.
module tb_audio_stream_fetch;

    logic        clk;
    logic        reset;
    logic        init_done;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [24:0] track_base;
    logic [23:0] track_len;
    logic        sdram_rd;
    logic [24:0] sdram_addr;
    logic        sdram_ac;
    logic [15:0] sdram_data;
    logic        sdram_wait;
    logic        fifo_wrreq;
    logic [15:0] fifo_data;
    logic [10:0] fifo_wrusedw;
    logic        fifo_wrfull;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [15:0] stall_cnt;

    int          n_checks;
    int          n_fail;
    int          ack_delay;
    bit          resp_en;
    logic [24:0] wa_q[$];

    audio_stream_fetch dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .init_done_i    (init_done),
        .start_i        (start),
        .stop_i         (stop),
        .loop_en_i      (loop_en),
        .track_base_i   (track_base),
        .track_len_i    (track_len),
        .sdram_rd_o     (sdram_rd),
        .sdram_addr_o   (sdram_addr),
        .sdram_ac_i     (sdram_ac),
        .sdram_data_i   (sdram_data),
        .sdram_wait_i   (sdram_wait),
        .fifo_wrreq_o   (fifo_wrreq),
        .fifo_data_o    (fifo_data),
        .fifo_wrusedw_i (fifo_wrusedw),
        .fifo_wrfull_i  (fifo_wrfull),
        .busy_o         (busy),
        .done_o         (done),
        .underrun_o     (underrun),
        .stall_cnt_o    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input logic [24:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder acks after ack_delay request cycles; logs every FIFO write before the next edge.
    initial begin
        int wcnt;
        wcnt       = 0;
        sdram_ac   = 1'b0;
        sdram_data = 16'h0;
        forever begin
            @(negedge clk);
            if (resp_en && sdram_rd) begin
                if (wcnt >= ack_delay) begin
                    sdram_ac   = 1'b1;
                    sdram_data = pat(sdram_addr);
                    wcnt       = 0;
                end else begin
                    sdram_ac = 1'b0;
                    wcnt++;
                end
            end else begin
                sdram_ac = 1'b0;
                wcnt     = 0;
            end
            #2;
            if (fifo_wrreq) begin
                check_eq("wdata", 32'(fifo_data), 32'(pat(sdram_addr)));
                wa_q.push_back(sdram_addr);
            end
        end
    end

    task automatic do_reset();
        resp_en      = 1'b0;
        reset        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        loop_en      = 1'b0;
        sdram_wait   = 1'b0;
        fifo_wrusedw = 11'd0;
        fifo_wrfull  = 1'b0;
        init_done    = 1'b1;
        ack_delay    = 2;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        wa_q.delete();
        resp_en = 1'b1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_rd"},       32'(sdram_rd),   32'd0);
        check_eq({pfx, "_addr"},     32'(sdram_addr), 32'd0);
        check_eq({pfx, "_wrreq"},    32'(fifo_wrreq), 32'd0);
        check_eq({pfx, "_busy"},     32'(busy),       32'd0);
        check_eq({pfx, "_done"},     32'(done),       32'd0);
        check_eq({pfx, "_underrun"}, 32'(underrun),   32'd0);
        check_eq({pfx, "_stall"},    32'(stall_cnt),  32'd0);
    endtask

    task automatic start_track(input logic [24:0] base, input logic [23:0] len);
        track_base = base;
        track_len  = len;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_writes(input string tag, input int n, input int limit);
        int c;
        c = 0;
        while (wa_q.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        check_eq(tag, 32'(wa_q.size()), 32'(n));
    endtask

    task automatic wait_rd(input string tag, input int limit);
        int c;
        c = 0;
        while (!sdram_rd && c < limit) begin
            @(negedge clk);
            c++;
        end
        check_eq(tag, 32'(sdram_rd), 32'd1);
    endtask

    initial begin
        int bad;
        int seen;
        logic [24:0] addr0;
        n_checks   = 0;
        n_fail     = 0;
        track_base = '0;
        track_len  = '0;

        // Reset state
        do_reset();
        check_reset_outputs("rst");

        // Basic fill: one full burst, a LEVEL gap, then the next burst
        start_track(25'h1000, 24'd600);
        wait_writes("fill_cnt", 256, 2000);
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] != 25'(32'h1000 + i)) bad++;
        check_eq("fill_addrs", 32'(bad), 32'd0);
        check_eq("fill_last", 32'(wa_q[255]), 32'h10FF);
        check_eq("fill_level_rd", 32'(sdram_rd), 32'd0);
        check_eq("fill_level_busy", 32'(busy), 32'd1);
        check_eq("fill_no_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        check_eq("fill_next_rd", 32'(sdram_rd), 32'd1);
        check_eq("fill_next_addr", 32'(sdram_addr), 32'h1100);
        check_eq("fill_underrun", 32'(underrun), 32'd1);

        // Non-looping end of track
        do_reset();
        start_track(25'h1000, 24'd300);
        wait_writes("end_cnt", 300, 3000);
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] != 25'(32'h1000 + i)) bad++;
        check_eq("end_addrs", 32'(bad), 32'd0);
        check_eq("end_last", 32'(wa_q[wa_q.size() - 1]), 32'h112B);
        check_eq("end_rd", 32'(sdram_rd), 32'd0);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_done", 32'(done), 32'd1);
        repeat (10) @(negedge clk);
        check_eq("end_no_more", 32'(wa_q.size()), 32'd300);

        // Loop wrap to track_base
        do_reset();
        loop_en = 1'b1;
        start_track(25'h20, 24'd5);
        wait_writes("loop_cnt", 256, 2000);
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] != 25'(32'h20 + (i % 5))) bad++;
        check_eq("loop_addrs", 32'(bad), 32'd0);
        check_eq("loop_done", 32'(done), 32'd0);
        check_eq("loop_busy", 32'(busy), 32'd1);

        // Low-water gating
        do_reset();
        fifo_wrusedw = 11'd1024;
        start_track(25'h0, 24'd1000);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sdram_rd) seen++;
        end
        check_eq("lw_hold_rd", 32'(seen), 32'd0);
        check_eq("lw_hold_busy", 32'(busy), 32'd1);
        fifo_wrusedw = 11'd1023;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (sdram_rd) seen = 1;
        end
        check_eq("lw_go_rd", 32'(seen), 32'd1);

        // Stop while a request is outstanding
        do_reset();
        ack_delay = 5;
        start_track(25'h300, 24'd100);
        wait_rd("stop_rd_seen", 50);
        addr0 = sdram_addr;
        stop  = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        bad  = 0;
        for (int c = 0; c < 20 && wa_q.size() < 1; c++) begin
            if (!sdram_rd || sdram_addr != addr0 || !busy) bad++;
            @(negedge clk);
        end
        check_eq("stop_hold", 32'(bad), 32'd0);
        check_eq("stop_one_write", 32'(wa_q.size()), 32'd1);
        check_eq("stop_rd", 32'(sdram_rd), 32'd0);
        check_eq("stop_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check_eq("stop_no_more", 32'(wa_q.size()), 32'd1);

        // Start gating and stall counting
        do_reset();
        init_done = 1'b0;
        start_track(25'h40, 24'd50);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sdram_rd) seen++;
        end
        check_eq("noinit_rd", 32'(seen), 32'd0);
        check_eq("noinit_busy", 32'(busy), 32'd0);
        init_done = 1'b1;
        stop      = 1'b1;
        start_track(25'h40, 24'd50);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("startstop_busy", 32'(busy), 32'd0);
        sdram_wait = 1'b1;
        ack_delay  = 6;
        start_track(25'h40, 24'd50);
        wait_writes("stall_first", 1, 100);
        sdram_wait = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("stall_cnt", 32'(stall_cnt), 32'd7);

        // Synchronous reset on an ack cycle
        do_reset();
        sdram_wait = 1'b1;
        ack_delay  = 3;
        start_track(25'h500, 24'd50);
        wait_rd("rstmid_rd_seen", 50);
        repeat (3) @(negedge clk);
        check_eq("rstmid_stall", 32'(stall_cnt), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rstmid");
        check_eq("rstmid_no_write", 32'(wa_q.size()), 32'd0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_stream_fetch.md
Name: audio_stream_fetch

Overview:
- Controller that keeps the audio playback FIFO, which feeds the I2S serializer, topped up from SDRAM.
- Issues fixed-length word-read bursts to its SDRAM arbiter port whenever the FIFO write-side level falls below a low-water mark.
- Walks a track region word by word, then stops or loops.
- Sits between the SDRAM arbiter (as one requester) and the write side of the 2048-word audio FIFO. It starts only after SD-card-to-SDRAM initialisation has completed.

Parameters:
- ADDR_W, 25, SDRAM word-address width.
- LVL_W, 11, FIFO wrusedw width. FIFO depth = 2**LVL_W.
- BURST_LEN, 256, words fetched per burst. Must be ≥1.
- LOW_WATER, 1024, a burst starts when level < LOW_WATER. Must be ≤ 2**LVL_W − BURST_LEN.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- init_done  in  1  SDRAM image load complete. Level-sensitive.
- start  in  1  one-cycle pulse: begin playback at track_base.
- stop  in  1  one-cycle pulse: abort playback.
- loop_en  in  1  1 = wrap to track_base at end of track.
- track_base  in  ADDR_W  first word address. Sampled on accepted start.
- track_len  in  24  track length in 16-bit words. Sampled on accepted start.
- sdram_rd  out  1  read request to arbiter.
- sdram_addr  out  ADDR_W  word address of the current request.
- sdram_ac  in  1  one-cycle acknowledge; sdram_data valid in the same cycle.
- sdram_data  in  16  read data.
- sdram_Wait  in  1  arbiter serving another requester (status only).
- fifo_wrreq  out  1  FIFO write strobe.
- fifo_data  out  16  FIFO write data.
- fifo_wrusedw  in  LVL_W  FIFO write-side fill level.
- fifo_wrfull  in  1  FIFO full.
- busy  out  1  playback active.
- done  out  1  sticky: non-looping track finished. Cleared by start.
- underrun  out  1  sticky: FIFO empty during playback after first burst. Cleared by start.
- stall_cnt  out  16  saturating count of request cycles with sdram_Wait=1. Cleared by start.

Behaviour:
- Reset values: sdram_rd=0, sdram_addr=0, fifo_wrreq=0, busy=0, done=0, underrun=0, stall_cnt=0, state=IDLE. Reset mid-burst drops sdram_rd at the next edge; no FIFO write occurs in the reset cycle.
- States: IDLE, LEVEL, BURST, DRAIN_STOP.
- IDLE:
  - start with init_done=1 → latch base, len; cur=base; remain=len; clear done, underrun, stall_cnt.
  - Then → LEVEL, or → IDLE with done=1 if len=0.
  - start with init_done=0 is ignored.
- LEVEL:
  - busy=1.
  - If fifo_wrusedw < LOW_WATER and fifo_wrfull=0 → BURST, with burst counter bcnt=BURST_LEN. The decision takes 1 cycle.
  - stop → IDLE.
- BURST:
  - sdram_rd=1 and sdram_addr=cur, both held stable until sdram_ac.
  - On sdram_ac, in the same cycle: fifo_wrreq=1, fifo_data=sdram_data (combinational pass-through, zero latency).
  - On sdram_ac, registered: cur+1, remain−1, bcnt−1.
  - The next request may be issued in the cycle after the ack (sdram_rd stays high).
  - Priority on an ack cycle:
    1. stop seen this cycle or earlier → IDLE, sdram_rd=0 next cycle.
    2. remain reaches 0 and loop_en=1 → cur=base, remain=len, continue.
    3. remain reaches 0 and loop_en=0 → IDLE, done=1.
    4. bcnt reaches 0 → LEVEL.
- Stop during BURST before the ack:
  - → DRAIN_STOP. The outstanding request stays asserted until sdram_ac; that word is written to the FIFO; then → IDLE.
  - An issued request is never withdrawn.
- Address arithmetic: ADDR_W-bit modulo 2**ADDR_W. The wrap is to track_base, not to 0, when loop_en=1.
- loop_en is sampled at each end-of-track.
- underrun: set when busy=1, at least one burst has completed, and fifo_wrusedw=0 with fifo_wrfull=0.
- stall_cnt: +1 per cycle where sdram_rd=1 and sdram_Wait=1. Saturates at 0xFFFF.
- start while busy: ignored. stop in IDLE: no effect. start and stop in the same cycle from IDLE: start is ignored.
- Overflow guarantee: the parameter constraint ensures a burst never overfills the FIFO. fifo_wrfull is checked only at burst entry.

Test Plan:
- Basic fill: init_done=1, base=0x1000, len=600, fifo_wrusedw=0 held, ack 2 cycles after each rd.
  → Exactly 256 writes with addresses 0x1000..0x10FF, then a LEVEL cycle, then the next burst starts at 0x1100.
- Non-loop end: len=300, level forced 0.
  → 300 writes; last address 0x112B; done=1; busy=0; sdram_rd=0 the cycle after the last ack.
- Loop wrap: base=0x20, len=5, loop_en=1, BURST_LEN=256.
  → Address sequence 20,21,22,23,24,20,21,… for 256 acks; done stays 0.
- Low-water gating: wrusedw=1024 → no rd for 100 cycles; drop to 1023 → sdram_rd=1 within 2 cycles.
- Stop mid-request: stop pulse while rd=1 and ack delayed 5 cycles.
  → rd held stable; one final fifo_wrreq on the ack; IDLE next cycle; busy=0.
- Reset, gating and status:
  - Synchronous reset mid-burst → all outputs at reset values next edge.
  - start with init_done=0 → no rd issued.
  - sdram_Wait=1 for 7 request cycles → stall_cnt=7.
  - wrusedw=0 after first burst → underrun=1.
